// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the writeback stage: opcode encodings, widths
// and the writeback FSM state type.
package cpu_pkg;

  localparam int DATA_W   = 16;
  localparam int STACK_W  = 12;
  localparam int STATUS_W = 8;
  localparam int REG_N    = 8;
  localparam int OPCODE_W = 6;

  localparam logic [OPCODE_W-1:0] OP_MULT = 6'b100001;

  typedef enum logic [0:0] {
    WB_IDLE     = 1'b0,
    WB_WRITE_HI = 1'b1
  } wb_state_t;

endpackage

// File: rtl/regfile_8x16.sv
// General-purpose register file: one synchronous write port, two
// combinational read ports, asynchronous active-low clear of every entry.
module regfile_8x16 #(
  parameter int DATA_W = 16,
  parameter int REG_N  = 8,
  localparam int AW    = $clog2(REG_N)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr1_i,
  input  logic [AW-1:0]     raddr2_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o
);

  logic [DATA_W-1:0] mem_q [REG_N];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < REG_N; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = mem_q[raddr1_i];
  assign rdata2_o = mem_q[raddr2_i];

endmodule

// File: rtl/alu_writeback.sv
// Writeback stage after the ALU: owns the GPR file, status register and stack
// pointer; MULT high words take an extra cycle. Optional macro WB_BYPASS_EN.
module alu_writeback #(
  parameter int                    DATA_W       = cpu_pkg::DATA_W,
  parameter int                    REG_N        = cpu_pkg::REG_N,
  parameter int                    STACK_W      = cpu_pkg::STACK_W,
  parameter logic [STACK_W-1:0]    STACK_RESET  = '0,
  parameter logic [7:0]            STATUS_RESET = 8'h00,
  localparam int                   AW           = $clog2(REG_N)
) (
  input  logic               CLOCK,
  input  logic               RESET_N,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [5:0]         in_opcode,
  input  logic               in_wr_en,
  input  logic [AW-1:0]      in_wr_addr,
  input  logic [DATA_W-1:0]  in_aluout1,
  input  logic [DATA_W-1:0]  in_aluout2,
  input  logic [7:0]         in_status,
  input  logic               in_stack_we,
  input  logic [STACK_W-1:0] in_stack,
  input  logic [AW-1:0]      rd_addr1,
  input  logic [AW-1:0]      rd_addr2,
  output logic [DATA_W-1:0]  rd_data1,
  output logic [DATA_W-1:0]  rd_data2,
  output logic [7:0]         status_q,
  output logic [STACK_W-1:0] stack_q,
  output logic               busy
);

  import cpu_pkg::*;

  // Handshake: a result is taken on any rising edge where in_valid and
  // in_ready are both high; in_ready depends only on registered state, so
  // upstream may hold in_valid (with stable payload) until that edge.

  wb_state_t          state_q, state_d;
  logic [DATA_W-1:0]  hi_data_q, hi_data_d;
  logic [AW-1:0]      hi_addr_q, hi_addr_d;
  logic [7:0]         status_d;
  logic [STACK_W-1:0] stack_d;

  logic               accept;
  logic               rf_we;
  logic [AW-1:0]      rf_waddr;
  logic [DATA_W-1:0]  rf_wdata;
  logic [DATA_W-1:0]  rf_rdata1;
  logic [DATA_W-1:0]  rf_rdata2;

  assign in_ready = (state_q == WB_IDLE);
  assign busy     = (state_q == WB_WRITE_HI);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= WB_IDLE;
      hi_data_q <= '0;
      hi_addr_q <= '0;
      status_q  <= STATUS_RESET;
      stack_q   <= STACK_RESET;
    end else begin
      state_q   <= state_d;
      hi_data_q <= hi_data_d;
      hi_addr_q <= hi_addr_d;
      status_q  <= status_d;
      stack_q   <= stack_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hi_data_d = hi_data_q;
    hi_addr_d = hi_addr_q;
    status_d  = status_q;
    stack_d   = stack_q;
    rf_we     = 1'b0;
    rf_waddr  = in_wr_addr;
    rf_wdata  = in_aluout1;
    case (state_q)
      WB_IDLE: begin
        if (accept) begin
          rf_we    = in_wr_en;
          status_d = in_status;
          if (in_stack_we) begin
            stack_d = in_stack;
          end
          // High word lands in the next register up, wrapping R7 -> R0.
          if ((in_opcode == OP_MULT) && in_wr_en) begin
            hi_data_d = in_aluout2;
            hi_addr_d = in_wr_addr + 1'b1;
            state_d   = WB_WRITE_HI;
          end
        end
      end
      WB_WRITE_HI: begin
        rf_we    = 1'b1;
        rf_waddr = hi_addr_q;
        rf_wdata = hi_data_q;
        state_d  = WB_IDLE;
      end
      default: begin
        state_d = WB_IDLE;
      end
    endcase
  end

  regfile_8x16 #(
    .DATA_W (DATA_W),
    .REG_N  (REG_N)
  ) u_regfile (
    .clk_i    (CLOCK),
    .rst_ni   (RESET_N),
    .we_i     (rf_we),
    .waddr_i  (rf_waddr),
    .wdata_i  (rf_wdata),
    .raddr1_i (rd_addr1),
    .raddr2_i (rd_addr2),
    .rdata1_o (rf_rdata1),
    .rdata2_o (rf_rdata2)
  );

`ifdef WB_BYPASS_EN
  // Forward whatever the register file is about to capture this cycle.
  assign rd_data1 = (rf_we && (rf_waddr == rd_addr1)) ? rf_wdata : rf_rdata1;
  assign rd_data2 = (rf_we && (rf_waddr == rd_addr2)) ? rf_wdata : rf_rdata2;
`else
  assign rd_data1 = rf_rdata1;
  assign rd_data2 = rf_rdata2;
`endif

endmodule
